ripple_count_monitor: RTL
=========================

Name: ripple_count_monitor

Overview:
- Downstream consumer of the 3-bit asynchronous (ripple) down counter; takes its raw `count` bus into the system clock domain.
- Synchronizes the bus and filters ripple transients.
- Checks that accepted values follow a strict modulo-2^WIDTH decrement sequence.
- Reports wrap events (0 -> max) and sequence errors as pulses, sticky flags and saturating statistics counters.

Parameters:
- WIDTH, 3, width of monitored count bus.
- SYNC_STAGES, 2, synchronizer flop stages (legal 2..4).
- WRAP_CNT_W, 8, width of wrap event counter.
- ERR_CNT_W, 4, width of sequence error counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  raw count from the ripple down counter; asynchronous to clk.
- enable  input  1  1 = sequence checking active; 0 = track only.
- clear_stats  input  1  synchronous clear of wrap_count, err_count, seq_error.
- count_sync  output  WIDTH  filtered, accepted count value.
- stable  output  1  last two synchronized samples equal.
- wrap_pulse  output  1  one-cycle pulse on legal 0 -> (2^WIDTH-1) step.
- err_pulse  output  1  one-cycle pulse on illegal step.
- seq_error  output  1  sticky error flag.
- wrap_count  output  WRAP_CNT_W  saturating count of wraps.
- err_count  output  ERR_CNT_W  saturating count of errors.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values (at rising clk with reset=1):
  - All sync stages, filter register, count_sync, reference register = 0.
  - stable, wrap_pulse, err_pulse, seq_error, wrap_count, err_count = 0.
  - FSM = INIT.
- Reset mid-operation aborts any pending acceptance; no pulse is emitted on that edge.
- Synchronizer: SYNC_STAGES-deep flop chain on count_in. Last stage is s_last.
- Filter:
  - filt <= s_last every edge.
  - Accept condition: s_last == filt.
  - stable <= (s_last == filt), registered.
  - A value must be seen on two consecutive synchronized samples to be accepted; single-cycle ripple transients are rejected.
- Latency: a clean step on count_in first captured at edge k updates count_sync at edge k+SYNC_STAGES+1 (k+3 at default). wrap_pulse/err_pulse assert in the same cycle count_sync changes.
- FSM states: INIT, TRACK.
  - INIT:
    - On first accept condition: ref <= s_last, count_sync <= s_last, go to TRACK if enable=1.
    - No checks, no pulses.
  - TRACK, accept condition and s_last != ref:
    - count_sync <= s_last, ref <= s_last.
    - Legal step: s_last == (ref - 1) mod 2^WIDTH.
    - Legal step with ref==0, s_last==2^WIDTH-1: wrap_pulse=1 for one cycle, wrap_count += 1.
    - Any other value (up-step, skip): err_pulse=1, seq_error <= 1, err_count += 1. The new value is adopted as reference (resync); stay in TRACK.
  - TRACK, accept with s_last == ref: no action.
  - enable=0 in any state:
    - Go to / stay in INIT.
    - count_sync continues to follow accepted values.
    - No pulses; statistics frozen.
- Saturation: wrap_count holds at all-ones, err_count holds at all-ones. The pulses still fire.
- clear_stats=1: wrap_count, err_count, seq_error <= 0 on that edge.
  - Coincident wrap/error event: clear wins (counters 0, seq_error 0). The pulse still fires.
  - Does not affect FSM, ref, or count_sync.
- Arithmetic is modulo 2^WIDTH. Counters are unsigned, no rollover.

Test Plan:
- Reset, count_in=3'b000, enable=1, hold 6 cycles -> count_sync=0, FSM TRACK, no pulses, all stats 0.
- Clean decrement 0,7,6,...,0,7, each held 8 cycles -> count_sync follows with 3-edge latency; wrap_pulse exactly twice (each 0->7); wrap_count=2; seq_error=0.
- From count_sync=5, drive count_in=3'b001 for 1 cycle (ripple glitch), then 3'b100 stable -> glitch never appears on count_sync; 4 accepted; no err_pulse.
- From 5, step to 2 (skip) and later 2->3 (up-step) -> two err_pulses; err_count=2; seq_error=1. Following 3->2 is legal with no error.
- Force 20 errors with ERR_CNT_W=4 -> err_count saturates at 15. Then clear_stats on the same edge as a wrap -> wrap_pulse=1, wrap_count=0, err_count=0, seq_error=0.
- Reset asserted mid-step (count_in changed, not yet accepted) -> all outputs 0 next cycle, FSM INIT, no pulse. After release, current count_in is adopted without error.

Source files
------------

// File: rtl/ripple_count_monitor.sv
// Synchronizes and de-glitches a ripple down-counter bus, then checks
// that accepted values follow a strict modulo decrement sequence.
module ripple_count_monitor #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int WRAP_CNT_W  = 8,
    parameter int ERR_CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  enable,
    input  logic                  clear_stats,
    output logic [WIDTH-1:0]      count_sync,
    output logic                  stable,
    output logic                  wrap_pulse,
    output logic                  err_pulse,
    output logic                  seq_error,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic [ERR_CNT_W-1:0]  err_count
);

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES:0]              warm_q;
    logic [WIDTH-1:0]                  s_last;
    logic [WIDTH-1:0]                  filt_q;
    logic [WIDTH-1:0]                  ref_q;
    logic [WIDTH-1:0]                  ref_dec;
    logic                              accept;
    logic                              upd;
    logic                              wrap_ev;
    logic                              err_ev;

    assign s_last  = sync_q[SYNC_STAGES-1];
    assign ref_dec = ref_q - WIDTH'(1);

    // Reset zeroes the chain, so acceptance waits until real samples
    // have filled it; otherwise a stale zero would be adopted first.
    assign accept = warm_q[SYNC_STAGES] && (s_last == filt_q);

    always_comb begin
        state_d = state_q;
        upd     = 1'b0;
        wrap_ev = 1'b0;
        err_ev  = 1'b0;
        unique case (1'b1)
            !enable: begin
                state_d = INIT;
                upd     = accept;
            end
            enable && (state_q == INIT): begin
                if (accept) begin
                    upd     = 1'b1;
                    state_d = TRACK;
                end
            end
            enable && (state_q == TRACK): begin
                if (accept && (s_last != ref_q)) begin
                    upd = 1'b1;
                    if (s_last == ref_dec) begin
                        wrap_ev = (ref_q == '0);
                    end else begin
                        err_ev = 1'b1;
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            sync_q     <= '0;
            warm_q     <= '0;
            filt_q     <= '0;
            ref_q      <= '0;
            count_sync <= '0;
            stable     <= 1'b0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], count_in};
            warm_q     <= {warm_q[SYNC_STAGES-1:0], 1'b1};
            filt_q     <= s_last;
            stable     <= (s_last == filt_q);
            wrap_pulse <= wrap_ev;
            err_pulse  <= err_ev;
            if (upd) begin
                count_sync <= s_last;
                ref_q      <= s_last;
            end
        end
    end

    // Clear beats a coincident event; the pulse itself is unaffected.
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            wrap_count <= '0;
            err_count  <= '0;
            seq_error  <= 1'b0;
        end else begin
            if (wrap_ev && (wrap_count != '1)) begin
                wrap_count <= wrap_count + WRAP_CNT_W'(1);
            end
            if (err_ev) begin
                seq_error <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule
